// File: rtl/rom_fetch_if.sv
// rom_fetch_if: ROM address/data bus plus the
// fetch-to-decode handshake and control inputs.
`timescale 1ns/1ps

interface rom_fetch_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  halt;

  modport master (
    output rom_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    input  rom_data,
    input  instr_ready,
    input  jump,
    input  jump_target,
    input  halt
  );

  modport slave (
    input  rom_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output rom_data,
    output instr_ready,
    output jump,
    output jump_target,
    output halt
  );
endinterface

// File: rtl/rom_fetch.sv
// rom_fetch: PC-driven ROM fetch with access-time
// wait counter and a one-entry instruction buffer.
`timescale 1ns/1ps

module rom_fetch #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_fetch_if.master   bus
);

  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] W_RELOAD =
    CW'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] W_RST_PC =
    ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_wcnt;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_valid;

  logic w_data_ok;
  logic w_slot_free;
  logic w_capture;

  assign w_data_ok   = (r_wcnt == '0);
  assign w_slot_free = !r_valid
                     || bus.instr_ready;
  assign w_capture   = w_data_ok
                     && !bus.halt
                     && w_slot_free;

  // Jump beats capture; a flushed buffer is
  // dropped regardless of instr_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= W_RST_PC;
      r_wcnt     <= W_RELOAD;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (bus.jump) begin
      r_pc    <= bus.jump_target;
      r_wcnt  <= W_RELOAD;
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr    <= bus.rom_data;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
      r_pc       <= r_pc + ADDR_WIDTH'(1);
      r_wcnt     <= W_RELOAD;
    end else begin
      if (r_valid && bus.instr_ready)
        r_valid <= 1'b0;
      if (!w_data_ok)
        r_wcnt <= r_wcnt - CW'(1);
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;

endmodule
